uart_cfg_sequencer: RTL and testbench
=====================================

Name: uart_cfg_sequencer

Overview:
- Master-side configuration sequencer for the UART link.
- On a start request it sends the configuration packets in order: data width, stop bits, parity mode, end-configuration.
- Each packet goes through the shared transmitter handshake. The sequencer then waits for the remote acknowledgment byte 8'hFF, with a timeout and bounded retries.
- When the end packet is acknowledged, it commits the new configuration to the local datapath. It sits between the main controller and the TX/RX engines.

Parameters:
- ACK_TIMEOUT_CYCLES, 5_000_000, clock cycles to wait for an acknowledgment (50 ms at 100 MHz).
- MAX_RETRIES, 3, re-sends allowed per packet after the first attempt.
- ACKN_BYTE, 8'hFF, acknowledgment value.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  single-cycle request to configure; ignored while busy_o=1
- cfg_i  in  6  requested {data_width[1:0], stop_bits[1:0], parity_mode[1:0]}
- tx_data_o  out  8  packet byte for the transmitter
- tx_start_o  out  1  single-cycle transmit strobe
- tx_done_i  in  1  transmitter finished the current byte (pulse)
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx_data_i valid (pulse)
- busy_o  out  1  sequence in progress
- done_o  out  1  single-cycle pulse when the configuration is committed
- fail_o  out  1  single-cycle pulse when the sequence is aborted
- cfg_o  out  6  active configuration driving the TX/RX datapath

Behaviour:
- Reset values:
  - cfg_o=6'b11_00_00 (8-bit data, 1 stop bit, even parity).
  - tx_data_o=0, tx_start_o=0, busy_o=0, done_o=0, fail_o=0.
  - FSM=IDLE; retry and timeout counters=0.
- Packet format: {4'b0000, option[1:0], id[1:0]}.
  - DW: id=01, option=cfg.data_width.
  - SB: id=10, option=cfg.stop_bits.
  - PM: id=11, option=cfg.parity_mode.
  - END: id=00, option=00.
- States: IDLE, CHECK, SEND, WAIT_TX, WAIT_ACK, COMMIT, ABORT.
- IDLE:
  - start_i=1 latches cfg_i into the pending register.
  - Packet index=0, retry=0, go to CHECK.
  - busy_o rises the cycle after start_i.
- CHECK (1 cycle):
  - If pending stop_bits[1]=1 (reserved code), go to ABORT.
  - Otherwise go to SEND.
- SEND (1 cycle):
  - tx_start_o=1, tx_data_o=current packet, go to WAIT_TX.
  - tx_data_o holds its value until the next SEND.
- WAIT_TX:
  - On tx_done_i, clear the timeout counter and go to WAIT_ACK.
  - rx_valid_i is ignored in this state.
- WAIT_ACK: the timeout counter increments each cycle.
  - rx_valid_i with rx_data_i=ACKN_BYTE:
    - If the packet is END, go to COMMIT.
    - Otherwise index++, retry=0, go to SEND.
  - rx_valid_i with any other byte counts as a NACK.
  - A counter reaching ACK_TIMEOUT_CYCLES-1 counts as a timeout.
  - NACK or timeout:
    - If retry<MAX_RETRIES, retry++ and go to SEND, re-sending the same packet.
    - Otherwise go to ABORT.
  - If a valid ACK arrives in the same cycle as the timeout, the ACK wins.
- COMMIT (1 cycle):
  - cfg_o <= pending, done_o=1, go to IDLE.
  - busy_o falls in the same cycle cfg_o updates.
- ABORT (1 cycle):
  - fail_o=1, cfg_o unchanged, go to IDLE.
- Other timing rules:
  - Minimum sequence latency = 4 × (1 SEND + tx time + ack time) + CHECK + COMMIT.
  - start_i during busy has no effect; cfg_i changes during busy have no effect.
- Asynchronous rst_i mid-sequence:
  - Immediate return to reset values, including cfg_o back to the standard configuration.
  - No done_o or fail_o pulse.
- Counter widths:
  - Timeout counter uses $clog2(ACK_TIMEOUT_CYCLES) bits.
  - Retry counter uses $clog2(MAX_RETRIES+1) bits.
  - Neither counter wraps: the timeout counter is cleared on every WAIT_ACK entry.

Test Plan:
- Happy path: reset, then start_i with cfg_i=6'b10_01_01, and the bench ACKs every packet.
  - TX bytes are 8'h09, 8'h06, 8'h07, 8'h00 in that order.
  - done_o pulses once; cfg_o=6'b10_01_01; busy_o low afterwards.
- NACK then retry: bench answers DW with 8'h00 then 8'hFF.
  - 8'h0D is sent twice (cfg_i=6'b11_00_00); sequence completes; done_o=1.
- Timeout exhaustion: ACK_TIMEOUT_CYCLES=16, MAX_RETRIES=3, bench never ACKs.
  - The first packet is sent exactly 4 times, 16 cycles apart after each tx_done_i.
  - fail_o pulses; cfg_o stays 6'b11_00_00.
- Reserved stop bits: start_i with cfg_i=6'b11_10_00.
  - No tx_start_o ever; fail_o pulses 2 cycles after start_i.
- Corner cases:
  - rx_valid_i=8'hFF during WAIT_TX is ignored: the sequencer still waits for a new ACK.
  - An ACK arriving on the timeout cycle advances to the next packet with no re-send.
  - start_i asserted mid-sequence is ignored.
- Reset mid-sequence: assert rst_i during WAIT_ACK of the PM packet.
  - All outputs return to reset values asynchronously; cfg_o=6'b11_00_00; no done_o or fail_o.
  - A subsequent start_i restarts from the DW packet.

Source files
------------

// File: rtl/uart_cfg_sequencer.sv
// uart_cfg_sequencer
//   Master-side configuration sequencer for the UART link. A start request
//   latches the requested configuration and sends four packets in order:
//   data width, stop bits, parity mode and end-of-configuration. Each packet
//   goes through the shared transmitter handshake. The sequencer then waits
//   for the remote acknowledgment byte, with a timeout and a bounded number
//   of re-sends. Once the end packet is acknowledged, the configuration is
//   committed to the local TX/RX datapath.
//
// Ports
//   clk_i, rst_i      system clock, asynchronous active-high reset
//   start_i           single-cycle configure request (ignored while busy_o)
//   cfg_i[5:0]        requested {data_width, stop_bits, parity_mode}
//   tx_data_o[7:0]    packet byte for the transmitter
//   tx_start_o        single-cycle transmit strobe
//   tx_done_i         transmitter finished the current byte
//   rx_data_i[7:0]    received byte, qualified by rx_valid_i
//   busy_o            sequence in progress
//   done_o / fail_o   single-cycle commit / abort pulses
//   cfg_o[5:0]        active configuration for the TX/RX datapath
module uart_cfg_sequencer #(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter logic [7:0]  ACKN_BYTE          = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] cfg_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [5:0] cfg_o
);

  localparam int unsigned TMO_W   = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [5:0]         CFG_STD   = 6'b11_00_00;

  typedef enum logic [2:0] {
    IDLE, CHECK, SEND, WAIT_TX, WAIT_ACK, COMMIT, ABORT
  } state_t;

  state_t             state, state_d;
  logic [5:0]         pend, pend_d;
  logic [1:0]         idx, idx_d;
  logic [RETRY_W-1:0] retry, retry_d;
  logic [TMO_W-1:0]   tmo, tmo_d;
  logic [7:0]         tx_data, tx_data_d;
  logic [5:0]         cfg, cfg_d;
  logic               ack, nack, tmo_hit;

  // Packet index 0..3 maps to DW, SB, PM, END.
  function automatic logic [7:0] pkt(input logic [5:0] c, input logic [1:0] i);
    case (i)
      2'd0:    pkt = {4'b0000, c[5:4], 2'b01};
      2'd1:    pkt = {4'b0000, c[3:2], 2'b10};
      2'd2:    pkt = {4'b0000, c[1:0], 2'b11};
      default: pkt = 8'h00;
    endcase
  endfunction

  assign ack     = rx_valid_i && (rx_data_i == ACKN_BYTE);
  assign nack    = rx_valid_i && (rx_data_i != ACKN_BYTE);
  assign tmo_hit = (tmo == TMO_LAST);

  always_comb begin
    state_d = state;
    pend_d  = pend;
    idx_d   = idx;
    retry_d = retry;
    tmo_d   = tmo;
    cfg_d   = cfg;
    case (state)
      IDLE: begin
        if (start_i) begin
          pend_d  = cfg_i;
          idx_d   = '0;
          retry_d = '0;
          state_d = CHECK;
        end
      end
      CHECK:   state_d = pend[3] ? ABORT : SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (tx_done_i) begin
          tmo_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tmo_d = tmo + 1'b1;
        // An ACK takes priority over a timeout landing in the same cycle.
        if (ack) begin
          if (idx == 2'd3) begin
            state_d = COMMIT;
          end else begin
            idx_d   = idx + 1'b1;
            retry_d = '0;
            state_d = SEND;
          end
        end else if (nack || tmo_hit) begin
          if (retry < RETRY_MAX) begin
            retry_d = retry + 1'b1;
            state_d = SEND;
          end else begin
            state_d = ABORT;
          end
        end
      end
      COMMIT: begin
        cfg_d   = pend;
        state_d = IDLE;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Byte is loaded on the way into SEND so it is valid alongside the strobe
    // and then held until the next SEND.
    tx_data_d = (state_d == SEND) ? pkt(pend_d, idx_d) : tx_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pend    <= '0;
      idx     <= '0;
      retry   <= '0;
      tmo     <= '0;
      tx_data <= '0;
      cfg     <= CFG_STD;
    end else begin
      state   <= state_d;
      pend    <= pend_d;
      idx     <= idx_d;
      retry   <= retry_d;
      tmo     <= tmo_d;
      tx_data <= tx_data_d;
      cfg     <= cfg_d;
    end
  end

  assign tx_data_o  = tx_data;
  assign tx_start_o = (state == SEND);
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == COMMIT);
  assign fail_o     = (state == ABORT);
  assign cfg_o      = cfg;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// tb_uart_cfg_sequencer
//   Randomized self-checking bench for uart_cfg_sequencer. A remote-side
//   responder answers each transmitted packet with an ACK, a NACK, silence
//   (timeout) or an ACK on the timeout cycle; a packet-level reference model
//   predicts the next byte, the retry outcome and the final configuration.
module tb_uart_cfg_sequencer;

  localparam int unsigned T  = 16;
  localparam int unsigned MR = 3;
  localparam logic [5:0] STD = 6'b11_00_00;

  localparam int R_ACK = 0, R_NACK = 1, R_TO = 2, R_ACKTO = 3;
  localparam int EV_BYTE = 0, EV_DONE = 1, EV_FAIL = 2, EV_NONE = 3;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [5:0] cfg_i;
  logic [7:0] tx_data_o;
  logic       tx_start_o;
  logic       tx_done_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       busy_o;
  logic       done_o;
  logic       fail_o;
  logic [5:0] cfg_o;

  int         n_vec = 0;
  int         n_err = 0;
  int         script[$];
  logic [5:0] active;

  uart_cfg_sequencer #(
    .ACK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(MR),
    .ACKN_BYTE(8'hFF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cfg_i(cfg_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .cfg_o(cfg_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected packet byte: {0000, option, id}
  function automatic logic [7:0] pkt(input logic [5:0] c, input int i);
    logic [1:0] opt[4];
    logic [1:0] id[4];
    opt = '{c[5:4], c[3:2], c[1:0], 2'b00};
    id  = '{2'b01, 2'b10, 2'b11, 2'b00};
    return {4'b0000, opt[i], id[i]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg"}, 32'(cfg_o), 32'(STD));
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_txs"}, 32'(tx_start_o), 0);
    check({tag, "_txd"}, 32'(tx_data_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_fail"}, 32'(fail_o), 0);
  endtask

  task automatic hard_reset;
    start_i = 0; tx_done_i = 0; rx_valid_i = 0;
    rst_i = 1;
    tick; tick;
    rst_i = 0;
    active = STD;
    tick;
  endtask

  task automatic wait_event(output int kind, output int n);
    kind = EV_NONE;
    n = 0;
    while (n < 200) begin
      if (tx_start_o) begin kind = EV_BYTE; return; end
      if (done_o)     begin kind = EV_DONE; return; end
      if (fail_o)     begin kind = EV_FAIL; return; end
      tick;
      n++;
    end
  endtask

  // flags: bit0 random chatter, bit1 stray ACK while the byte is still being
  // transmitted, bit2 start request mid-sequence. rst_pkt >= 0 resets the
  // block while waiting for that packet's acknowledgment.
  task automatic run_seq(input logic [5:0] cfg, input int flags, input int rst_pkt);
    logic [5:0] pend;
    logic [7:0] exp_byte;
    int idx, retry, exp_kind, kind, n, resp, d, exp_gap, r;
    bit fin;
    pend = cfg; idx = 0; retry = 0; fin = 0;
    cfg_i = cfg; start_i = 1;
    tick;
    start_i = 0; cfg_i = 6'($urandom);
    check("busy_rise", 32'(busy_o), 1);
    exp_kind = pend[3] ? EV_FAIL : EV_BYTE;
    exp_byte = pkt(pend, 0);
    exp_gap  = 1;
    while (!fin) begin
      wait_event(kind, n);
      check("event", kind, exp_kind);
      if (exp_gap >= 0) check("latency", n, exp_gap);
      exp_gap = -1;
      if (kind != exp_kind) begin
        hard_reset;
        fin = 1;
      end else if (kind == EV_DONE) begin
        tick;
        check("done_pulse", 32'(done_o), 0);
        check("busy_fall", 32'(busy_o), 0);
        check("cfg_commit", 32'(cfg_o), 32'(pend));
        active = pend;
        fin = 1;
      end else if (kind == EV_FAIL) begin
        tick;
        check("fail_pulse", 32'(fail_o), 0);
        check("busy_fall", 32'(busy_o), 0);
        check("cfg_kept", 32'(cfg_o), 32'(active));
        fin = 1;
      end else begin
        check("tx_byte", 32'(tx_data_o), 32'(exp_byte));
        tick;
        check("tx_hold", 32'(tx_data_o), 32'(exp_byte));
        check("tx_strobe", 32'(tx_start_o), 0);
        d = ((flags & 6) != 0) ? $urandom_range(1, 3) :
            ((flags & 1) != 0) ? $urandom_range(0, 3) : 0;
        for (int k = 0; k < d; k++) begin
          if (((flags & 2) != 0 && k == 0) || ((flags & 1) != 0 && $urandom_range(0, 3) == 0)) begin
            rx_valid_i = 1; rx_data_i = 8'hFF;
          end
          if (((flags & 4) != 0 && k == 0) || ((flags & 1) != 0 && $urandom_range(0, 7) == 0)) begin
            start_i = 1; cfg_i = 6'($urandom);
          end
          tick;
          rx_valid_i = 0; start_i = 0;
        end
        tx_done_i = 1;
        tick;
        tx_done_i = 0;
        if (rst_pkt == idx) begin
          repeat (3) tick;
          #2 rst_i = 1;
          #1 check_reset_outputs("async_rst");
          tick; tick;
          rst_i = 0;
          active = STD;
          for (int k = 0; k < 4; k++) begin
            tick;
            check("rst_no_done", 32'(done_o), 0);
            check("rst_no_fail", 32'(fail_o), 0);
          end
          return;
        end
        if (script.size() > 0) resp = script.pop_front();
        else begin
          r = $urandom_range(0, 9);
          resp = (r < 5) ? R_ACK : (r < 7) ? R_NACK : (r < 8) ? R_TO : R_ACKTO;
        end
        case (resp)
          R_ACK, R_NACK: begin
            repeat ($urandom_range(0, T - 2)) tick;
            rx_valid_i = 1;
            rx_data_i  = (resp == R_ACK) ? 8'hFF : 8'($urandom_range(0, 254));
            tick;
            rx_valid_i = 0;
            exp_gap = 0;
          end
          R_ACKTO: begin
            repeat (T - 1) tick;
            rx_valid_i = 1; rx_data_i = 8'hFF;
            tick;
            rx_valid_i = 0;
            exp_gap = 0;
          end
          default: exp_gap = T;
        endcase
        if (resp == R_ACK || resp == R_ACKTO) begin
          if (idx == 3) exp_kind = EV_DONE;
          else begin idx++; retry = 0; exp_kind = EV_BYTE; end
        end else begin
          if (retry < int'(MR)) begin retry++; exp_kind = EV_BYTE; end
          else exp_kind = EV_FAIL;
        end
        exp_byte = pkt(pend, idx);
      end
    end
  endtask

  initial begin
    rst_i = 1; start_i = 0; cfg_i = '0; tx_done_i = 0;
    rx_data_i = '0; rx_valid_i = 0; active = STD;
    tick; tick;
    check_reset_outputs("reset");
    rst_i = 0;
    tick;

    // Reserved stop-bit code aborts without transmitting.
    run_seq(6'b11_10_00, 0, -1);
    // Every attempt of the first packet times out.
    script = '{R_TO, R_TO, R_TO, R_TO};
    run_seq(6'b11_00_00, 0, -1);
    // Happy path: 09, 06, 07, 00.
    script = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b10_01_01, 0, -1);
    // NACK on DW then ACK: 0D sent twice.
    script = '{R_NACK, R_ACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b11_00_00, 0, -1);
    // ACK coinciding with the timeout advances without a re-send.
    script = '{R_ACKTO, R_ACKTO, R_ACK, R_ACKTO};
    run_seq(6'b01_01_10, 0, -1);
    // Stray ACK while transmitting is ignored; then silence forces a re-send.
    script = '{R_TO, R_ACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b00_00_01, 2, -1);
    // start_i / cfg_i activity mid-sequence has no effect.
    script = '{R_ACK, R_NACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b10_00_10, 4, -1);

    for (int i = 0; i < 25; i++) begin
      logic [5:0] c;
      c = 6'($urandom);
      c[3] = ($urandom_range(0, 7) == 0);
      script.delete();
      run_seq(c, 1, -1);
      repeat ($urandom_range(0, 3)) tick;
    end

    // Reset during the PM acknowledgment wait, then a clean restart.
    script = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b10_01_01, 0, -1);
    script = '{R_ACK, R_ACK};
    run_seq(6'b01_00_11, 0, 2);
    script = '{R_ACK, R_ACK, R_ACK, R_ACK};
    run_seq(6'b00_01_00, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
